// File: rtl/i2f_pkg.sv
// i2f_pkg: shared constants, width helpers and result record for the int2float arbiter
package i2f_pkg;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RUP = 3'd2;
  localparam logic [2:0] RM_RDN = 3'd3;
  localparam int MAX_WID = 64;
  localparam int MAX_IW = 3;
  typedef struct packed {
    logic [MAX_WID-1:0] data;
    logic [MAX_IW-1:0]  id;
  } i2f_res_t;
  function automatic int i2f_emsb(input int wid);
    return wid == 64 ? 10 : 7;
  endfunction
  function automatic int i2f_fmsb(input int wid);
    return wid == 64 ? 51 : 22;
  endfunction
endpackage

// File: rtl/i2f_res_fifo.sv
// i2f_res_fifo: synchronous result FIFO, async active-low reset
// Ports: clk, rst_n; push/din write side; pop/dout/empty read side (dout shows the head entry).
module i2f_res_fifo
  import i2f_pkg::*;
#(
  parameter int W     = $bits(i2f_res_t),
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  assign dout  = mem[rp[AW-1:0]];
  assign empty = wp == rp;
endmodule

// File: rtl/int2float_arb.sv
// int2float_arb: round-robin arbiter sharing one int2float converter among NREQ requesters
// Ports: req_vld/req_data/req_rm/req_rdy requester handshakes; cv_ce/cv_rm/cv_i drive the
// converter, cv_o/cv_vld return from it; res_vld/res_data/res_id/res_rdy result stream; busy.
module int2float_arb
  import i2f_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WID    = 32,
  parameter int LAT    = 1,
  parameter int FDEPTH = 4,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [NREQ*WID-1:0] req_data,
  input  logic [NREQ*3-1:0]   req_rm,
  output logic [NREQ-1:0]     req_rdy,
  output logic                cv_ce,
  output logic [2:0]          cv_rm,
  output logic [WID-1:0]      cv_i,
  input  logic [WID-1:0]      cv_o,
  input  logic                cv_vld,
  output logic                res_vld,
  output logic [WID-1:0]      res_data,
  output logic [IW-1:0]       res_id,
  input  logic                res_rdy,
  output logic                busy
);
  localparam int CW = $clog2(FDEPTH + 1);
  logic [CW-1:0]   credit;
  logic [IW-1:0]   ptr, gnt_id, iss_id;
  logic [NREQ-1:0] gnt;
  logic [LAT-1:0]  tag_vld;
  logic [IW-1:0]   tag_id [LAT];
  logic            acc, pop, empty, unused_res;
  i2f_res_t        din, dout;
  int              j;
  // Scan downward so the last hit is the nearest valid requester at or after ptr.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req_vld[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        gnt_id = IW'(j);
      end
    end
  end
  assign req_rdy = (rst_n && credit != '0) ? gnt : '0;
  assign acc     = |req_rdy;
  assign pop     = res_vld & res_rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit  <= CW'(FDEPTH);
      ptr     <= '0;
      cv_ce   <= 1'b0;
      cv_i    <= '0;
      cv_rm   <= '0;
      iss_id  <= '0;
      tag_vld <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      credit <= credit - CW'(acc) + CW'(pop);
      cv_ce  <= acc;
      if (acc) begin
        ptr    <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        cv_i   <= req_data[int'(gnt_id)*WID +: WID];
        cv_rm  <= req_rm[int'(gnt_id)*3 +: 3];
        iss_id <= gnt_id;
      end
      tag_vld[0] <= cv_ce;
      tag_id[0]  <= iss_id;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  // The tag, not cv_vld, decides the push so a stale converter output after reset is dropped.
  assign din = '{data: MAX_WID'(cv_o), id: MAX_IW'(tag_id[LAT-1])};
  i2f_res_fifo #(.W($bits(i2f_res_t)), .DEPTH(FDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_vld[LAT-1]),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .empty (empty)
  );
  assign res_vld    = !empty;
  assign res_data   = dout.data[WID-1:0];
  assign res_id     = dout.id[IW-1:0];
  assign unused_res = ^dout;
  assign busy       = cv_ce | (|tag_vld) | res_vld;
  a_tag_align: assert property (@(posedge clk) disable iff (!rst_n) cv_vld == tag_vld[LAT-1]);
endmodule

// File: tb/tb_int2float_arb.sv
// tb_int2float_arb: vector, directed and random checks of int2float_arb with a behavioural converter
module tb_int2float_arb;
  localparam int NREQ = 4, WID = 32, LAT = 1, FDEPTH = 4;
  logic                clk = 0;
  logic                rst_n = 0;
  logic [NREQ-1:0]     req_vld = '0;
  logic [NREQ*WID-1:0] req_data = '0;
  logic [NREQ*3-1:0]   req_rm = '0;
  logic [NREQ-1:0]     req_rdy;
  logic                cv_ce;
  logic [2:0]          cv_rm;
  logic [WID-1:0]      cv_i;
  logic [WID-1:0]      cv_o = '0;
  logic                cv_vld = 0;
  logic                res_vld;
  logic [WID-1:0]      res_data;
  logic [1:0]          res_id;
  logic                res_rdy = 1;
  logic                busy;
  int checks = 0, failures = 0;

  int2float_arb #(.NREQ(NREQ), .WID(WID), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_rm(req_rm),
    .req_rdy(req_rdy), .cv_ce(cv_ce), .cv_rm(cv_rm), .cv_i(cv_i), .cv_o(cv_o), .cv_vld(cv_vld),
    .res_vld(res_vld), .res_data(res_data), .res_id(res_id), .res_rdy(res_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference int32 -> float32 conversion from the rounding rules.
  function automatic logic [31:0] i2f(input logic [31:0] v, input logic [2:0] rm);
    logic s;
    logic [63:0] m, k, r, h;
    int p, e, sh;
    logic up;
    s = v[31];
    m = s ? 64'(-longint'($signed(v))) : 64'(v);
    if (m == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 32; b++) if (m[b]) p = b;
    e = 127 + p;
    up = 0;
    if (p <= 23) k = m << (23 - p);
    else begin
      sh = p - 23;
      k = m >> sh;
      r = m & ((64'd1 << sh) - 1);
      h = 64'd1 << (sh - 1);
      if (rm == 3'd0) up = (r > h) || (r == h && k[0]);
      else if (rm == 3'd2) up = (r != 0) && !s;
      else if (rm == 3'd3) up = (r != 0) && s;
    end
    k = k + 64'(up);
    if (k == (64'd1 << 24)) begin
      k = k >> 1;
      e++;
    end
    return {s, 8'(e), k[22:0]};
  endfunction

  // Converter with latency 1; deliberately not reset so stale outputs can appear.
  always @(posedge clk) begin
    cv_vld <= cv_ce;
    if (cv_ce) cv_o <= i2f(cv_i, cv_rm);
  end

  // Scoreboard: issue-order queue, own round-robin pointer, outstanding count as credit view.
  typedef struct {logic [31:0] f; int id;} exp_t;
  exp_t q[$];
  exp_t e;
  int mptr = 0, outst = 0, g;
  logic [NREQ-1:0] eg;
  logic found;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      outst = 0;
    end else begin
      eg = '0;
      found = 0;
      if (outst < FDEPTH)
        for (int k = 0; k < NREQ; k++)
          if (!found && req_vld[(mptr + k) % NREQ]) begin
            found = 1;
            eg[(mptr + k) % NREQ] = 1'b1;
          end
      chk("grant", req_rdy, eg);
      chk("busy", busy, outst > 0);
      chk("credit_bound", outst <= FDEPTH, 1);
      if (|req_rdy) begin
        g = 0;
        for (int k = 0; k < NREQ; k++) if (req_rdy[k]) g = k;
        q.push_back('{i2f(req_data[g*32 +: 32], req_rm[g*3 +: 3]), g});
        mptr = (g + 1) % NREQ;
        outst++;
      end
      if (res_vld && res_rdy) begin
        if (q.size() == 0) chk("spurious_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("res_data", res_data, e.f);
          chk("res_id", res_id, e.id);
        end
        outst--;
      end
    end
  end

  typedef struct {logic [31:0] d; logic [2:0] rm; int req; logic [31:0] f;} vec_t;
  vec_t vt[12];

  task automatic do_reset();
    req_vld = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int n, w;
    vt[0]  = '{32'd1,          3'd0, 0, 32'h3F800000};
    vt[1]  = '{32'hFFFFFFFF,   3'd0, 0, 32'hBF800000};
    vt[2]  = '{32'd0,          3'd0, 0, 32'h00000000};
    vt[3]  = '{32'd16777217,   3'd0, 2, 32'h4B800000};
    vt[4]  = '{32'd16777217,   3'd2, 2, 32'h4B800001};
    vt[5]  = '{32'd16777217,   3'd1, 1, 32'h4B800000};
    vt[6]  = '{-32'd16777217,  3'd3, 3, 32'hCB800001};
    vt[7]  = '{-32'd16777217,  3'd2, 3, 32'hCB800000};
    vt[8]  = '{32'd16777219,   3'd0, 1, 32'h4B800002};
    vt[9]  = '{32'h7FFFFFFF,   3'd0, 1, 32'h4F000000};
    vt[10] = '{32'h80000000,   3'd0, 0, 32'hCF000000};
    vt[11] = '{32'd33554435,   3'd5, 2, 32'h4C000000};
    rst_n = 0;
    req_vld = '1;
    @(posedge clk);
    #1;
    chk("rst_cv_ce", cv_ce, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cv_i", cv_i, 0);
    chk("rst_cv_rm", cv_rm, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    @(posedge clk);
    #1 rst_n = 1;
    req_vld = '0;
    foreach (vt[v]) begin
      @(posedge clk);
      #1 req_vld = '0;
      req_vld[vt[v].req] = 1'b1;
      req_data[vt[v].req*32 +: 32] = vt[v].d;
      req_rm[vt[v].req*3 +: 3] = vt[v].rm;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", v), req_rdy, 4'b1 << vt[v].req);
      @(posedge clk);
      #1 req_vld = '0;
      @(negedge clk);
      n = 1;
      while (!res_vld && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d_latency", v), n, 3);
      chk($sformatf("vec%0d_data", v), res_data, vt[v].f);
      chk($sformatf("vec%0d_id", v), res_id, vt[v].req);
    end
    // Round-robin streaming with downstream always ready.
    do_reset();
    res_rdy = 1;
    req_vld = '1;
    for (int k = 0; k < NREQ; k++) req_data[k*32 +: 32] = 32'(100 * k + 7);
    req_rm = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), req_rdy, i < 8 ? 4'b1 << (i % 4) : 4'b0);
      chk($sformatf("rr_res_vld%0d", i), res_vld, i >= 3 && i <= 10);
      @(posedge clk);
      #1 if (i == 7) req_vld = '0;
    end
    // Reset while a conversion is in flight, then backpressure with all requesters valid.
    do_reset();
    @(posedge clk);
    #1 req_vld = 4'b0010;
    req_data[32 +: 32] = 32'd5;
    @(negedge clk);
    chk("flight_grant", req_rdy, 4'b0010);
    @(posedge clk);
    #1 req_vld = '0;
    @(negedge clk);
    chk("flight_issue", cv_ce, 1);
    @(posedge clk);
    #1 rst_n = 0;
    req_vld = '1;
    #1;
    chk("mid_rst_cv_ce", cv_ce, 0);
    chk("mid_rst_res_vld", res_vld, 0);
    chk("mid_rst_req_rdy", req_rdy, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cv_i", cv_i, 0);
    chk("mid_rst_res_data", {res_id, res_data}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    res_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("bp_grant%0d", i), req_rdy, i < 4 ? 4'b1 << i : 4'b0);
      chk($sformatf("bp_res_vld%0d", i), res_vld, i >= 3);
    end
    @(posedge clk);
    #1 res_rdy = 1;
    @(negedge clk);
    chk("bp_pop_cycle_rdy", req_rdy, 0);
    chk("bp_pop_head_id", res_id, 0);
    @(posedge clk);
    #1 res_rdy = 0;
    @(negedge clk);
    chk("bp_regrant", req_rdy, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    chk("bp_single_grant", req_rdy, 0);
    @(posedge clk);
    #1 req_vld = '0;
    res_rdy = 1;
    // Random traffic against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1 req_vld = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++)
        req_data[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom();
      req_rm = 12'($urandom);
      res_rdy = $urandom_range(0, 3) != 0;
    end
    @(posedge clk);
    #1 req_vld = '0;
    res_rdy = 1;
    w = 0;
    while ((busy || q.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", w < 100, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int2float_arb.md
# int2float_arb

Round-robin arbiter and sequencer that shares one `int2float` conversion unit among `NREQ` requesters. It accepts integer/rounding-mode requests over valid/ready handshakes and drives the unit's `ce`/`rm`/`i` inputs one conversion per cycle. It tags each conversion with its requester ID and returns results, in issue order, through a credit-protected result FIFO with downstream backpressure. It sits between the integer-producing stages of the estimator pipeline and the shared converter.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WID`, 32: integer/float width (32 or 64), passed to the converter.
- `LAT`, 1: converter latency, in cycles, from `ce` to `o_vld`.
- `FDEPTH`, 4: result FIFO depth; also the credit count (power of two, ≥2).

Ports (`IW = $clog2(NREQ)`):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_vld`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WID  per-requester two's-complement integer; requester k uses slice [k*WID +: WID].
- `req_rm`  in  NREQ*3  per-requester rounding mode; requester k uses slice [k*3 +: 3].
- `req_rdy`  out  NREQ  one-hot grant; a transfer occurs when `req_vld[k] & req_rdy[k]`.
- `cv_ce`  out  1  converter clock enable; high for exactly the issue cycles.
- `cv_rm`  out  3  converter rounding mode.
- `cv_i`  out  WID  converter integer input.
- `cv_o`  in  WID  converter float output.
- `cv_vld`  in  1  converter `o_vld`.
- `res_vld`  out  1  result available.
- `res_data`  out  WID  float result.
- `res_id`  out  IW  requester index of the result.
- `res_rdy`  in  1  downstream accepts the result.
- `busy`  out  1  any conversion is in the issue register, the tag pipe or the FIFO.

## Operation
- **Credit counter.** Counts 0..FDEPTH and resets to FDEPTH.
  - Decrements on an accepted request and increments on a FIFO pop; both in one cycle leaves it unchanged.
  - The FIFO can never overflow, because a request is only accepted while credit > 0.
- **Arbitration.** Combinational; computed only while credit > 0.
  - The grant goes to the first requester with `req_vld` set, searching from `ptr` upward with wrap.
  - At most one `req_rdy` bit is high. `req_rdy` does not depend on `req_vld` of any other requester beyond the priority search.
  - On a transfer, `ptr` ← grant+1 mod NREQ. `ptr` resets to 0.
- **Issue register.**
  - On a transfer: captures `{data, rm, id}`, and in the next cycle drives `cv_ce=1`, `cv_i` and `cv_rm`.
  - With no transfer: `cv_ce=0`, and `cv_i`/`cv_rm` hold their last values.
- **Tag pipe.** Length LAT; each entry holds `{valid, id}` and shifts every cycle.
  - Its output entry aligns with the converter result.
  - A FIFO push occurs when the tag output is valid, writing `{cv_o, id}`.
  - `cv_vld` is not used for the push. A mismatch between `cv_vld` and the tag valid bit is an assertion failure.
- **FIFO (`i2f_res_fifo`).**
  - `res_vld` = not empty. `res_data`/`res_id` show the head entry.
  - A pop occurs on `res_vld & res_rdy`. Push and pop in the same cycle are allowed at any occupancy.
- **Rounding modes** are passed through unchanged: 0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4–7 truncate.
- **Reset** (async assert, synchronous deassert expected at chip level).
  - Clears credit to FDEPTH, `ptr`, the issue register, the tag valids and the FIFO.
  - Output values under reset: `cv_ce=0`, `res_vld=0`, `req_rdy=0`, `busy=0`, `cv_i`/`cv_rm`/`res_data`/`res_id`=0.
  - Conversions in flight are discarded. A stale `cv_vld` from the unreset converter is ignored, because the tag is invalid.

## Timing
- A transfer in cycle t gives `cv_ce` high in t+1, the converter result and push at end of t+1+LAT, and `res_vld` in t+2+LAT. With LAT=1 this is 3 cycles.
- Sustained throughput is 1 conversion/cycle when `res_rdy` is held high and FDEPTH ≥ LAT+3.
- With `res_rdy` low, exactly FDEPTH requests are accepted, then `req_rdy` = 0 until the first pop. `req_rdy` rises in the cycle after that pop.
- `req_rdy` is combinational from `req_vld`, credit and `ptr`. All other outputs are registered.

## Structure
- Package `i2f_pkg` holds:
  - the rounding-mode constants `RM_RNE`, `RM_RTZ`, `RM_RUP`, `RM_RDN`;
  - the width function giving EMSB/FMSB from WID;
  - the struct `i2f_res_t {data, id}`.
- Sub-module `i2f_res_fifo`: synchronous FIFO with async active-low reset, parameterised on width and depth.
- The arbiter, the credit counter, the issue register and the tag pipe live in the top module.

## Test plan
- Req0 sends 1 (RNE), with `res_rdy=1`:
  - In cycle 3, `res_data`=0x3F800000 and `res_id`=0.
  - -1 returns 0xBF800000, and 0 returns 0x00000000.
- Req2 sends 16777217 twice, first with rm=0 (RNE) and then rm=2 (RUP):
  - The results, in order, are 0x4B800000 then 0x4B800001, both with id 2.
- All 4 requesters are valid continuously with `res_rdy=1`:
  - Grants go 0,1,2,3,0,… with one result per cycle and ids in grant order.
- `res_rdy=0`, all requesters valid:
  - Exactly 4 transfers occur, then `req_rdy`=0.
  - One pop restores exactly one grant, to the next requester in round-robin order.
- Assert `rst_n` low one cycle after issue, while a conversion is in flight:
  - No result appears, and all outputs go to their reset values.
  - After release, credit is 4 and the first grant goes to requester 0.
- Random valid/ready stimulus, 10k cycles:
  - Results match a reference model in issue order.
  - Credit plus FIFO occupancy plus conversions in flight equals FDEPTH every cycle.
